// File: rtl/proc_trace_checker.sv
// Shadow trace pipeline for TinyRV1 benches: carries the fetch trace through
// NSTAGES stages under per-stage stall/squash and checks each writeback-stage
// retirement against an expected-trace FIFO loaded by the bench.
module proc_trace_checker #(
  parameter int unsigned NSTAGES   = 5,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned EXP_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         f_val,
  input  logic [XLEN-1:0]              f_addr,
  input  logic [XLEN-1:0]              f_inst,
  input  logic [NSTAGES-1:0]           stall,
  input  logic [NSTAGES-1:0]           squash,
  input  logic [XLEN-1:0]              w_data,
  input  logic                         exp_push,
  input  logic [XLEN-1:0]              exp_addr,
  input  logic [XLEN-1:0]              exp_data,
  input  logic                         exp_dchk,
  output logic                         exp_full,
  output logic [$clog2(EXP_DEPTH):0]   exp_count,
  output logic                         w_val,
  output logic [XLEN-1:0]              w_addr,
  output logic [XLEN-1:0]              w_inst,
  output logic                         retire,
  output logic [31:0]                  retired_count,
  output logic [15:0]                  mismatch_count,
  output logic                         err,
  output logic [XLEN-1:0]              err_addr,
  output logic                         overflow
);

  localparam int unsigned W  = NSTAGES - 1;
  localparam int unsigned PW = $clog2(EXP_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic            dchk;
  } exp_t;

  logic            val_q  [1:NSTAGES-1];
  logic [XLEN-1:0] addr_q [1:NSTAGES-1];
  logic [XLEN-1:0] inst_q [1:NSTAGES-1];
  logic            val_n  [1:NSTAGES-1];
  logic [XLEN-1:0] addr_n [1:NSTAGES-1];
  logic [XLEN-1:0] inst_n [1:NSTAGES-1];
  logic            src_val  [1:NSTAGES-1];
  logic [XLEN-1:0] src_addr [1:NSTAGES-1];
  logic [XLEN-1:0] src_inst [1:NSTAGES-1];

  logic [NSTAGES-1:0] stall_eff;

  exp_t            exp_mem [EXP_DEPTH];
  exp_t            head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            mism;

  // A stall at stage j also holds every stage upstream of it
  for (genvar k = 0; k < NSTAGES; k++) begin : g_stall
    assign stall_eff[k] = |stall[NSTAGES-1:k];
  end

  // Next-state of the shadow stages: hold on stall, else load the stage behind
  always_comb begin
    src_val[1]  = f_val;
    src_addr[1] = f_addr;
    src_inst[1] = f_inst;
    for (int k = 2; k < NSTAGES; k++) begin
      src_val[k]  = val_q[k-1];
      src_addr[k] = addr_q[k-1];
      src_inst[k] = inst_q[k-1];
    end
    for (int k = 1; k < NSTAGES; k++) begin
      val_n[k]  = val_q[k] & ~squash[k];
      addr_n[k] = addr_q[k];
      inst_n[k] = inst_q[k];
      if (!stall_eff[k]) begin
        val_n[k]  = src_val[k] & ~squash[k-1] & ~stall_eff[k-1];
        addr_n[k] = src_addr[k];
        inst_n[k] = src_inst[k];
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < NSTAGES; k++) begin
        val_q[k]  <= 1'b0;
        addr_q[k] <= '0;
        inst_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k < NSTAGES; k++) begin
        val_q[k]  <= val_n[k];
        addr_q[k] <= addr_n[k];
        inst_q[k] <= inst_n[k];
      end
    end
  end

  assign w_val  = val_q[W];
  assign w_addr = addr_q[W];
  assign w_inst = inst_q[W];
  assign retire = val_q[W] & ~stall_eff[W] & ~squash[W];

  assign head      = exp_mem[rd_ptr];
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(EXP_DEPTH));
  assign pop       = retire & ~empty;
  assign push_ok   = exp_push & (~full | pop);
  assign mism      = retire & (empty | (w_addr != head.addr) |
                               (head.dchk & (w_data !== head.data)));
  assign exp_full  = full;
  assign exp_count = cnt;

  // Expected-trace storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) exp_mem[wr_ptr] <= '{addr: exp_addr, data: exp_data, dchk: exp_dchk};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Retire/mismatch counters and sticky error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count  <= '0;
      mismatch_count <= '0;
      err            <= 1'b0;
      err_addr       <= '0;
      overflow       <= 1'b0;
    end else begin
      if (retire) retired_count <= retired_count + 32'd1;
      if (mism) begin
        if (mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
        if (!err) err_addr <= w_addr;
      end
      if (exp_push && !push_ok) overflow <= 1'b1;
      if (mism || (exp_push && !push_ok)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_trace_checker.sv
// Randomised and directed bench for proc_trace_checker with a queue-based
// reference model and a decoupled per-cycle scoreboard monitor.
module tb_proc_trace_checker;

  localparam int NS  = 5;
  localparam int W   = NS - 1;
  localparam int DEP = 4;
  localparam int CWT = $clog2(DEP) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            f_val;
  logic [31:0]     f_addr, f_inst;
  logic [NS-1:0]   stall, squash;
  logic [31:0]     w_data;
  logic            exp_push;
  logic [31:0]     exp_addr, exp_data;
  logic            exp_dchk;
  logic            exp_full;
  logic [CWT-1:0]  exp_count;
  logic            w_val;
  logic [31:0]     w_addr, w_inst;
  logic            retire;
  logic [31:0]     retired_count;
  logic [15:0]     mismatch_count;
  logic            err;
  logic [31:0]     err_addr;
  logic            overflow;

  proc_trace_checker #(.NSTAGES(NS), .XLEN(32), .EXP_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .f_val(f_val), .f_addr(f_addr), .f_inst(f_inst),
    .stall(stall), .squash(squash), .w_data(w_data), .exp_push(exp_push),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_dchk(exp_dchk),
    .exp_full(exp_full), .exp_count(exp_count), .w_val(w_val), .w_addr(w_addr),
    .w_inst(w_inst), .retire(retire), .retired_count(retired_count),
    .mismatch_count(mismatch_count), .err(err), .err_addr(err_addr),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; logic c; } ent_t;
  typedef struct { logic [31:0] a; logic [31:0] i; } ret_t;
  typedef struct {
    logic wv; logic [31:0] wa; logic [31:0] wi; logic ret;
    logic [31:0] rc; logic [15:0] mc; logic er; logic [31:0] ea; logic ov;
    int cnt; logic full;
  } st_t;

  // Reference model state
  logic        m_val  [NS];
  logic [31:0] m_addr [NS];
  logic [31:0] m_inst [NS];
  ent_t        mq[$];
  logic [31:0] m_retired;
  logic [15:0] m_mc;
  logic        m_err;
  logic [31:0] m_err_addr;
  logic        m_ovf;

  st_t  sq[$];
  ret_t rq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   wd_ovr = 1'b0;
  logic [31:0] wd_val = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return a * 32'd3 + 32'h11;
  endfunction

  // Deepest stage currently requesting a stall, -1 if none
  function automatic int top_stall();
    int t = -1;
    for (int j = 0; j < NS; j++) if (stall[j]) t = j;
    return t;
  endfunction

  function automatic logic m_ret();
    return m_val[W] && (top_stall() < W) && !squash[W];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NS; k++) begin
      m_val[k] = 1'b0; m_addr[k] = '0; m_inst[k] = '0;
    end
    mq.delete();
    m_retired = '0; m_mc = '0; m_err = 1'b0; m_err_addr = '0; m_ovf = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs driven during the cycle
  task automatic model_edge();
    int  s;
    logic ret, mis, fl, pp, acc;
    if (rst) return;
    s   = top_stall();
    ret = m_ret();
    mis = ret && (mq.size() == 0 || m_addr[W] != mq[0].a ||
                  (mq[0].c && w_data !== mq[0].d));
    fl  = (mq.size() == DEP);
    pp  = ret && (mq.size() > 0);
    acc = exp_push && (!fl || pp);
    if (pp) void'(mq.pop_front());
    if (acc) mq.push_back('{a: exp_addr, d: exp_data, c: exp_dchk});
    if (ret) m_retired = m_retired + 32'd1;
    if (mis) begin
      if (m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
      if (!m_err) m_err_addr = m_addr[W];
      m_err = 1'b1;
    end
    if (exp_push && !acc) begin m_ovf = 1'b1; m_err = 1'b1; end
    for (int k = W; k >= 1; k--) begin
      if (k <= s) begin
        m_val[k] = m_val[k] && !squash[k];
      end else begin
        logic sv; logic [31:0] sa, si;
        if (k == 1) begin sv = f_val; sa = f_addr; si = f_inst; end
        else begin sv = m_val[k-1]; sa = m_addr[k-1]; si = m_inst[k-1]; end
        m_addr[k] = sa;
        m_inst[k] = si;
        m_val[k]  = sv && !squash[k-1] && (k - 1 > s);
      end
    end
  endtask

  // One cycle: clock the model, drive new inputs, queue the expected outputs
  task automatic step(input bit fv, input logic [31:0] fa, input logic [31:0] fi,
                      input logic [NS-1:0] st, input logic [NS-1:0] sqs,
                      input bit p, input logic [31:0] ea, input logic [31:0] ed,
                      input bit ec);
    st_t e;
    @(posedge clk); #1;
    model_edge();
    f_val = fv; f_addr = fa; f_inst = fi; stall = st; squash = sqs;
    exp_push = p; exp_addr = ea; exp_data = ed; exp_dchk = ec;
    w_data = wd_ovr ? wd_val : hash(m_addr[W]);
    e.wv = m_val[W]; e.wa = m_addr[W]; e.wi = m_inst[W]; e.ret = m_ret();
    e.rc = m_retired; e.mc = m_mc; e.er = m_err; e.ea = m_err_addr; e.ov = m_ovf;
    e.cnt = mq.size(); e.full = (mq.size() == DEP);
    sq.push_back(e);
    if (e.ret) rq.push_back('{a: m_addr[W], i: m_inst[W]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic fetch(input logic [31:0] a);
    step(1, a, a ^ 32'h0000_0013, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic expect_push(input logic [31:0] a, input logic [31:0] d, input bit c);
    step(0, '0, '0, '0, '0, 1, a, d, c);
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  // Scoreboard monitor: one status record per cycle, one retire record per retirement
  initial forever begin
    st_t  e;
    ret_t r;
    @(negedge clk);
    if (sq.size() > 0) begin
      e = sq.pop_front();
      if (!rst) begin
        chk("w_val", 32'(w_val), 32'(e.wv));
        chk("w_addr", w_addr, e.wa);
        chk("w_inst", w_inst, e.wi);
        chk("retire", 32'(retire), 32'(e.ret));
        chk("retired_count", retired_count, e.rc);
        chk("mismatch_count", 32'(mismatch_count), 32'(e.mc));
        chk("err", 32'(err), 32'(e.er));
        chk("err_addr", err_addr, e.ea);
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("exp_count", 32'(exp_count), 32'(e.cnt));
        chk("exp_full", 32'(exp_full), 32'(e.full));
      end
    end
    if (!rst && retire === 1'b1) begin
      if (rq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL retire_order: got retire of %h expected no retirement", w_addr);
      end else begin
        r = rq.pop_front();
        chk("retire_addr", w_addr, r.a);
        chk("retire_inst", w_inst, r.i);
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_w_val"}, 32'(w_val), 32'd0);
    chk({tag, "_w_addr"}, w_addr, 32'd0);
    chk({tag, "_retire"}, 32'(retire), 32'd0);
    chk({tag, "_exp_count"}, 32'(exp_count), 32'd0);
    chk({tag, "_exp_full"}, 32'(exp_full), 32'd0);
    chk({tag, "_retired"}, retired_count, 32'd0);
    chk({tag, "_mismatch"}, 32'(mismatch_count), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_err_addr"}, err_addr, 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [31:0] pc, epc;
    rst = 1'b1;
    f_val = 0; f_addr = '0; f_inst = '0; stall = '0; squash = '0; w_data = '0;
    exp_push = 0; exp_addr = '0; exp_data = '0; exp_dchk = 0;
    m_reset();
    repeat (2) @(posedge clk);
    mid();
    chk_reset_state("por");
    rst = 1'b0;

    // Single instruction, no stalls: NSTAGES-1 cycles to writeback
    wd_ovr = 1; wd_val = 32'd5;
    expect_push(32'h200, 32'd5, 1);
    fetch(32'h200);
    idle(3);
    idle(1);
    mid();
    chk("latency_retire", 32'(retire), 32'd1);
    chk("latency_addr", w_addr, 32'h200);
    idle(2);
    mid();
    chk("s1_retired", retired_count, 32'd1);
    chk("s1_err", 32'(err), 32'd0);
    chk("s1_exp_count", 32'(exp_count), 32'd0);
    wd_ovr = 0;

    // stall[2] held for two cycles mid-stream, fetch held meanwhile
    expect_push(32'h200, hash(32'h200), 1);
    expect_push(32'h204, hash(32'h204), 1);
    expect_push(32'h208, hash(32'h208), 1);
    fetch(32'h200);
    fetch(32'h204);
    step(1, 32'h208, 32'h208 ^ 32'h13, 5'b00100, '0, 0, '0, '0, 0);
    step(1, 32'h208, 32'h208 ^ 32'h13, 5'b00100, '0, 0, '0, '0, 0);
    fetch(32'h208);
    idle(6);
    mid();
    chk("s2_retired", retired_count, 32'd4);
    chk("s2_mismatch", 32'(mismatch_count), 32'd0);

    // Taken branch: kill stage 1 and the current fetch
    expect_push(32'h300, hash(32'h300), 1);
    expect_push(32'h304, hash(32'h304), 1);
    expect_push(32'h400, hash(32'h400), 1);
    fetch(32'h300);
    fetch(32'h304);
    fetch(32'h308);
    step(1, 32'h30C, 32'h30C ^ 32'h13, '0, 5'b00011, 0, '0, '0, 0);
    fetch(32'h400);
    idle(6);
    mid();
    chk("s3_retired", retired_count, 32'd7);
    chk("s3_err", 32'(err), 32'd0);

    // Data mismatches and an address-only entry
    wd_ovr = 1; wd_val = 32'd8;
    expect_push(32'h204, 32'd7, 1);
    expect_push(32'h208, 32'd9, 1);
    expect_push(32'h20C, 32'h1234, 0);
    fetch(32'h204);
    fetch(32'h208);
    fetch(32'h20C);
    idle(6);
    mid();
    chk("s4_mismatch", 32'(mismatch_count), 32'd2);
    chk("s4_err", 32'(err), 32'd1);
    chk("s4_err_addr", err_addr, 32'h204);
    chk("s4_retired", retired_count, 32'd10);
    wd_ovr = 0;

    // FIFO boundaries
    for (int i = 0; i < 4; i++) expect_push(32'h500 + 32'(4 * i), hash(32'h500 + 32'(4 * i)), 1);
    expect_push(32'h510, hash(32'h510), 1);
    mid();
    chk("s5_full", 32'(exp_full), 32'd1);
    chk("s5_count4", 32'(exp_count), 32'd4);
    chk("s5_no_ovf_yet", 32'(overflow), 32'd0);
    idle(1);
    mid();
    chk("s5_overflow", 32'(overflow), 32'd1);
    chk("s5_count_after_drop", 32'(exp_count), 32'd4);
    fetch(32'h500);
    idle(3);
    expect_push(32'h514, hash(32'h514), 1);
    mid();
    chk("s5_retire_while_full", 32'(retire), 32'd1);
    idle(1);
    mid();
    chk("s5_count_pushpop", 32'(exp_count), 32'd4);
    chk("s5_full_kept", 32'(exp_full), 32'd1);

    // Asynchronous reset with W live and stalled
    fetch(32'h700);
    idle(3);
    step(0, '0, '0, 5'b10000, '0, 0, '0, '0, 0);
    #1;
    rst = 1'b1;
    m_reset();
    rq.delete();
    #1;
    chk_reset_state("midrst");
    @(negedge clk); #1;
    stall = '0;
    rst = 1'b0;

    // Fresh sequence after reset, then a retire with nothing expected
    expect_push(32'h800, hash(32'h800), 1);
    expect_push(32'h804, hash(32'h804), 1);
    fetch(32'h800);
    fetch(32'h804);
    idle(6);
    mid();
    chk("s6_retired", retired_count, 32'd2);
    chk("s6_err", 32'(err), 32'd0);
    fetch(32'h900);
    idle(6);
    mid();
    chk("s6_unexpected_err", 32'(err), 32'd1);
    chk("s6_unexpected_cnt", 32'(mismatch_count), 32'd1);
    chk("s6_unexpected_addr", err_addr, 32'h900);

    // Randomised traffic against the model
    pc = 32'h1000; epc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      logic [NS-1:0] st, sqs;
      bit fv, p, ec;
      st  = ($urandom_range(7) == 0) ? NS'(1 << $urandom_range(NS - 1)) : '0;
      sqs = ($urandom_range(9) == 0) ? NS'($urandom) : '0;
      fv  = ($urandom_range(3) != 0);
      p   = ($urandom_range(2) == 0);
      ec  = 1'($urandom);
      wd_ovr = ($urandom_range(15) == 0);
      wd_val = $urandom;
      step(fv, pc, $urandom, st, sqs, p, epc, hash(epc), ec);
      if (fv && st == '0) pc = pc + 32'd4;
      if (p) epc = epc + 32'd4;
    end
    wd_ovr = 0;
    idle(8);
    mid();
    chk("retire_queue_drained", 32'(rq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_trace_checker.md
# proc_trace_checker

Parametrised trace pipeline and self-checker for TinyRV1 processor benches. It takes the per-cycle fetch trace (address, instruction) and carries it through a configurable number of shadow pipeline stages. Per-stage stall and squash keep the shadow copy aligned with the processor, and the block presents the writeback-stage trace. Each retirement is compared against an expected-trace FIFO loaded by the bench, and the block keeps retire, mismatch and error state.

## Interface
Parameters:
- NSTAGES, 5, pipeline stages including F; W is stage NSTAGES-1; legal range 2..8
- XLEN, 32, address/instruction/data width
- EXP_DEPTH, 16, expected-trace FIFO entries; power of two, at least 2

Ports (clock, then reset; reset is asynchronous and active-high):
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous active-high reset
- f_val  in  1  fetch-stage trace valid
- f_addr  in  XLEN  fetch address
- f_inst  in  XLEN  fetch instruction
- stall  in  NSTAGES  per-stage hold request, bit k = stage k
- squash  in  NSTAGES  per-stage kill, bit k = stage k
- w_data  in  XLEN  processor writeback trace data
- exp_push  in  1  push expected entry
- exp_addr  in  XLEN  expected retire address
- exp_data  in  XLEN  expected writeback data
- exp_dchk  in  1  1 = compare data, 0 = address only (no-writeback instructions)
- exp_full  out  1  FIFO full
- exp_count  out  $clog2(EXP_DEPTH)+1  FIFO occupancy
- w_val  out  1  W stage holds a live instruction
- w_addr  out  XLEN  W-stage address
- w_inst  out  XLEN  W-stage instruction
- retire  out  1  retirement this cycle
- retired_count  out  32  retirements since reset, wraps
- mismatch_count  out  16  mismatching retirements, saturates at 0xFFFF
- err  out  1  sticky: mismatch, unexpected retire, or overflow seen
- err_addr  out  XLEN  w_addr of first mismatch/unexpected retire
- overflow  out  1  sticky: push while full was dropped

## Operation
- Stage registers k = 1..NSTAGES-1 hold {val, addr, inst}. Stage 0 is the f_* inputs, which are not registered.
- Effective stall: stall_eff[k] = OR of stall[j] for j ≥ k. A downstream stall therefore holds every upstream stage.
- Per edge, for k ≥ 1:
  - If stall_eff[k]: stage k holds its value. squash[k] still clears val.
  - Else: stage k loads stage k-1. Loaded val = val[k-1] & ~squash[k-1] & ~stall_eff[k-1], so a stall boundary inserts a bubble.
  - A live, unstalled stage k whose squash[k]=1 is not held; it is overwritten by the incoming bubble or instruction.
- retire = val[W] & ~stall_eff[W] & ~squash[W]. Address and instruction are not cleared after retirement, only val.
- Check on retire (combinational against the FIFO head):
  - FIFO empty → unexpected retire: mismatch.
  - Otherwise mismatch = (w_addr != head.addr) | (head.dchk & (w_data !== head.data)). Case inequality, so X data mismatches when checked.
  - The head pops on every retire when the FIFO is non-empty, match or not.
- On mismatch: mismatch_count += 1 (saturating) and err ← 1. err_addr is loaded only on the first mismatch (err was 0).
- FIFO push:
  - Accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the entry is dropped and overflow ← 1 and err ← 1.
  - Pushing into an empty FIFO does not bypass to a same-cycle retire; that retire is unexpected.
- The read and write pointers wrap modulo EXP_DEPTH. Occupancy is a separate counter, 0..EXP_DEPTH.

## Timing
- Reset (async, any cycle, including mid-stall): all val = 0; addr/inst = 0; FIFO empty; exp_count = 0; exp_full = 0; retire = 0; counters = 0; err = 0; err_addr = 0; overflow = 0. Outputs take these values immediately on assertion.
- First edge after deassertion samples inputs normally.
- Latency F → W: NSTAGES-1 cycles with no stalls. An instruction fetched in cycle c appears with w_val = 1 in cycle c+NSTAGES-1.
- retire, the mismatch decision and exp head are combinational in the same cycle. Counters, err, err_addr and FIFO state update at the next edge.
- exp_full and exp_count reflect registered state. Push and pop in the same cycle leave exp_count unchanged.
- retired_count wraps 0xFFFFFFFF → 0. mismatch_count holds at 0xFFFF.

## Test plan
- No stalls, NSTAGES=5: push {0x200,5,1}; fetch 0x200 in cycle 2 with w_data=5 at W → retire in cycle 6; err=0; retired_count=1; exp_count back to 0.
- Stall[2] held 2 cycles mid-stream: stages 0–2 hold, stage 3 gets 2 bubbles. Sequence 0x200, 0x204, 0x208 retires in order with a 2-cycle gap; retired_count=3; no mismatch.
- Squash[1] and squash[0] together (taken branch): the two wrong-path instructions never retire. Expected list without them checks clean; w_val=0 in their slots.
- Data mismatch: expect {0x204,7,1}, w_data=8 → mismatch_count=1, err=1, err_addr=0x204. A second mismatch at 0x208 leaves err_addr=0x204 and sets mismatch_count=2. exp_dchk=0 with any data → no mismatch.
- FIFO boundaries, EXP_DEPTH=4: 4 pushes → exp_full=1. A 5th push alone → overflow=1, exp_count=4. Push and retire in the same cycle while full → accepted, count stays 4. A retire on empty → unexpected, err=1.
- Reset asserted mid-run while W is live and stall is high → all outputs clear in the same cycle. After release, a fresh sequence checks clean from retired_count=0.
